// File: rtl/axis_pkg.sv
// Shared types and helpers for the frame length adjust stage.
package axis_pkg;

  localparam int LEN_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2,
    DROP = 2'd3
  } state_t;

  // Padding target never exceeds the truncation limit, so a max below min wins.
  function automatic logic [31:0] eff_min(input logic [31:0] len_min, input logic [31:0] len_max);
    return ((len_max != 32'd0) && (len_max < len_min)) ? len_max : len_min;
  endfunction

endpackage

// File: rtl/axis_frame_len_adjust_if.sv
// Byte-wide AXI-Stream bundle with source (master) and sink (slave) views.
interface axis_frame_len_adjust_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_len_adjust.sv
// Pads short frames to a minimum length, truncates long ones at a maximum,
// and strobes per-frame length/adjustment status. Fully registered output.
module axis_frame_len_adjust
  import axis_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    USER_WIDTH = 1,
  parameter int                    LEN_WIDTH  = LEN_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = 8'h00,
  parameter logic                  TRUNC_USER = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_frame_len_adjust_if.slave  s_axis,
  axis_frame_len_adjust_if.master m_axis,
  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,
  output logic                  status_valid,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_padded,
  output logic                  status_truncated
);

  generate
    if (DATA_WIDTH != 8) begin : g_width_check
      $error("axis_frame_len_adjust supports DATA_WIDTH=8 only");
    end
  endgenerate

  localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;

  state_t                  state_reg, state_next;
  logic [LEN_WIDTH-1:0]    in_cnt_reg, in_cnt_next;
  logic [LEN_WIDTH-1:0]    out_cnt_reg, out_cnt_next;
  logic [LEN_WIDTH-1:0]    min_reg, min_next;
  logic [LEN_WIDTH-1:0]    max_reg, max_next;
  logic [USER_WIDTH-1:0]   last_user_reg, last_user_next;

  logic [DATA_WIDTH-1:0]   m_data_reg, m_data_next;
  logic                    m_valid_reg, m_valid_next;
  logic                    m_last_reg, m_last_next;
  logic [USER_WIDTH-1:0]   m_user_reg, m_user_next;

  logic                    st_valid_reg, st_valid_next;
  logic [LEN_WIDTH-1:0]    st_len_reg, st_len_next;
  logic                    st_pad_reg, st_pad_next;
  logic                    st_trunc_reg, st_trunc_next;

  logic                    load_en;
  logic                    s_ready;
  logic                    s_fire;
  logic [LEN_WIDTH-1:0]    cur_min;
  logic [LEN_WIDTH-1:0]    cur_max;
  logic [LEN_WIDTH-1:0]    cnt_inc;
  logic [LEN_WIDTH-1:0]    pad_inc;

  assign load_en = !m_valid_reg || m_axis.tready;
  assign s_fire  = s_axis.tvalid && s_ready;

  // Limits come straight from the ports on the first beat, then from the latched copy.
  assign cur_max = (state_reg == IDLE) ? length_max : max_reg;
  assign cur_min = (state_reg == IDLE) ? LEN_WIDTH'(eff_min(32'(length_min), 32'(length_max))) : min_reg;
  assign cnt_inc = (in_cnt_reg == CNT_MAX) ? CNT_MAX : in_cnt_reg + LEN_WIDTH'(1);
  assign pad_inc = out_cnt_reg + LEN_WIDTH'(1);

  always_comb begin
    s_ready = 1'b0;
    case (state_reg)
      IDLE, XFER: s_ready = load_en;
      PAD:        s_ready = 1'b0;
      DROP:       s_ready = 1'b1;
      default:    s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    in_cnt_next    = in_cnt_reg;
    out_cnt_next   = out_cnt_reg;
    min_next       = min_reg;
    max_next       = max_reg;
    last_user_next = last_user_reg;
    m_data_next    = m_data_reg;
    m_valid_next   = m_valid_reg;
    m_last_next    = m_last_reg;
    m_user_next    = m_user_reg;
    st_valid_next  = 1'b0;
    st_len_next    = st_len_reg;
    st_pad_next    = st_pad_reg;
    st_trunc_next  = st_trunc_reg;

    case (state_reg)
      IDLE, XFER: begin
        if (s_fire) begin
          min_next     = cur_min;
          max_next     = cur_max;
          in_cnt_next  = cnt_inc;
          m_valid_next = 1'b1;
          m_data_next  = s_axis.tdata;
          m_last_next  = s_axis.tlast;
          m_user_next  = s_axis.tuser;
          if (s_axis.tlast) begin
            st_valid_next = 1'b1;
            st_len_next   = cnt_inc;
            st_trunc_next = 1'b0;
            if (cnt_inc >= cur_min) begin
              st_pad_next = 1'b0;
              in_cnt_next = '0;
              state_next  = IDLE;
            end else begin
              st_pad_next    = 1'b1;
              m_last_next    = 1'b0;
              last_user_next = s_axis.tuser;
              out_cnt_next   = cnt_inc;
              state_next     = PAD;
            end
          end else if ((cur_max != '0) && (cnt_inc == cur_max)) begin
            m_last_next = 1'b1;
            m_user_next = {USER_WIDTH{TRUNC_USER}};
            state_next  = DROP;
          end else begin
            state_next = XFER;
          end
        end else if (load_en) begin
          m_valid_next = 1'b0;
        end
      end

      PAD: begin
        if (load_en) begin
          m_valid_next = 1'b1;
          m_data_next  = PAD_BYTE;
          m_user_next  = last_user_reg;
          m_last_next  = (pad_inc == min_reg);
          out_cnt_next = pad_inc;
          if (pad_inc == min_reg) begin
            in_cnt_next = '0;
            state_next  = IDLE;
          end
        end
      end

      DROP: begin
        if (load_en) begin
          m_valid_next = 1'b0;
        end
        if (s_fire) begin
          in_cnt_next = cnt_inc;
          if (s_axis.tlast) begin
            st_valid_next = 1'b1;
            st_len_next   = cnt_inc;
            st_pad_next   = 1'b0;
            st_trunc_next = 1'b1;
            in_cnt_next   = '0;
            state_next    = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
      min_reg       <= '0;
      max_reg       <= '0;
      last_user_reg <= '0;
      m_data_reg    <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      m_user_reg    <= '0;
      st_valid_reg  <= 1'b0;
      st_len_reg    <= '0;
      st_pad_reg    <= 1'b0;
      st_trunc_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_cnt_reg    <= in_cnt_next;
      out_cnt_reg   <= out_cnt_next;
      min_reg       <= min_next;
      max_reg       <= max_next;
      last_user_reg <= last_user_next;
      m_data_reg    <= m_data_next;
      m_valid_reg   <= m_valid_next;
      m_last_reg    <= m_last_next;
      m_user_reg    <= m_user_next;
      st_valid_reg  <= st_valid_next;
      st_len_reg    <= st_len_next;
      st_pad_reg    <= st_pad_next;
      st_trunc_reg  <= st_trunc_next;
    end
  end

  assign s_axis.tready    = s_ready;
  assign m_axis.tdata     = m_data_reg;
  assign m_axis.tvalid    = m_valid_reg;
  assign m_axis.tlast     = m_last_reg;
  assign m_axis.tuser     = m_user_reg;
  assign status_valid     = st_valid_reg;
  assign status_frame_len = st_len_reg;
  assign status_padded    = st_pad_reg;
  assign status_truncated = st_trunc_reg;

endmodule

// File: tb/tb_axis_frame_len_adjust.sv
// Directed-vector and random-backpressure bench for axis_frame_len_adjust.
module tb_axis_frame_len_adjust;
  import axis_pkg::*;

  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_frame_len_adjust_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s_if();
  axis_frame_len_adjust_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m_if();

  logic [LW-1:0] length_min, length_max, status_frame_len;
  logic          status_valid, status_padded, status_truncated;

  axis_frame_len_adjust dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .length_min       (length_min),
    .length_max       (length_max),
    .status_valid     (status_valid),
    .status_frame_len (status_frame_len),
    .status_padded    (status_padded),
    .status_truncated (status_truncated)
  );

  typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
  typedef struct { logic [LW-1:0] len; logic padded; logic trunc; } stat_t;
  typedef struct { int mn; int mx; int len; logic [7:0] base; logic [7:0] step;
                   int exp_out; logic exp_pad; logic exp_trunc; } vec_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  stat_t obs_st[$];
  stat_t exp_st[$];
  logic [7:0] fd[64];
  logic       fu[64];
  vec_t       vecs[9];
  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Downstream ready: always 1, or a coin flip each cycle.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: record transfers/status and verify output holds under stall.
  initial begin
    logic  pv, pr, prst;
    beat_t pb, b;
    stat_t s;
    pv = 1'b0; pr = 1'b0; prst = 1'b0;
    pb.data = '0; pb.last = 1'b0; pb.user = 1'b0;
    forever begin
      @(negedge clk);
      if (prst && pv && !pr) begin
        checks++;
        if (!(m_if.tvalid && m_if.tdata == pb.data && m_if.tlast == pb.last && m_if.tuser == pb.user)) begin
          errors++;
          $display("FAIL stall_hold got v=%0b d=%02h l=%0b u=%0b want v=1 d=%02h l=%0b u=%0b",
                   m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser, pb.data, pb.last, pb.user);
        end
      end
      if (rst && m_if.tvalid && m_if.tready) begin
        b.data = m_if.tdata; b.last = m_if.tlast; b.user = m_if.tuser;
        obs_q.push_back(b);
      end
      if (status_valid) begin
        s.len = status_frame_len; s.padded = status_padded; s.trunc = status_truncated;
        obs_st.push_back(s);
      end
      pv = m_if.tvalid; pr = m_if.tready; prst = rst;
      pb.data = m_if.tdata; pb.last = m_if.tlast; pb.user = m_if.tuser;
    end
  end

  // Reference: behavioural frame-level description of pad/truncate.
  task automatic model(input int mn, input int mx, input int len);
    int eff;
    beat_t b;
    stat_t s;
    eff = (mx != 0 && mx < mn) ? mx : mn;
    s.len = LW'(len);
    if (mx != 0 && len > mx) begin
      for (int k = 0; k < mx; k++) begin
        b.data = fd[k]; b.last = (k == mx - 1); b.user = (k == mx - 1) ? 1'b1 : fu[k];
        exp_q.push_back(b);
      end
      s.padded = 1'b0; s.trunc = 1'b1;
    end else if (len < eff) begin
      for (int k = 0; k < len; k++) begin
        b.data = fd[k]; b.last = 1'b0; b.user = fu[k];
        exp_q.push_back(b);
      end
      for (int k = len; k < eff; k++) begin
        b.data = 8'h00; b.last = (k == eff - 1); b.user = fu[len-1];
        exp_q.push_back(b);
      end
      s.padded = 1'b1; s.trunc = 1'b0;
    end else begin
      for (int k = 0; k < len; k++) begin
        b.data = fd[k]; b.last = (k == len - 1); b.user = fu[k];
        exp_q.push_back(b);
      end
      s.padded = 1'b0; s.trunc = 1'b0;
    end
    exp_st.push_back(s);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    logic acc;
    int   n;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = l; s_if.tuser = u;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL s_ready_timeout got ready=0 want ready=1 within 1000 cycles");
    end
  endtask

  task automatic send_frame(input int len);
    for (int k = 0; k < len; k++) send_beat(fd[k], (k == len - 1), fu[k]);
  endtask

  task automatic wait_done(input int nb, input int ns);
    int n;
    n = 0;
    while (!(obs_q.size() >= nb && obs_st.size() >= ns) && n < 20000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 20000) begin
      errors++;
      $display("FAIL drain_timeout got beats=%0d stat=%0d want beats=%0d stat=%0d", obs_q.size(), obs_st.size(), nb, ns);
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic compare_all(input string tag);
    int nb, ns;
    chk({tag, "_beat_count"}, obs_q.size(), exp_q.size());
    chk({tag, "_stat_count"}, obs_st.size(), exp_st.size());
    nb = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    ns = (obs_st.size() < exp_st.size()) ? obs_st.size() : exp_st.size();
    for (int i = 0; i < nb; i++) begin
      checks++;
      if (obs_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL %s_beat%0d got d=%02h l=%0b u=%0b want d=%02h l=%0b u=%0b", tag, i,
                 obs_q[i].data, obs_q[i].last, obs_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
      end
    end
    for (int i = 0; i < ns; i++) begin
      checks++;
      if (obs_st[i] != exp_st[i]) begin
        errors++;
        $display("FAIL %s_stat%0d got len=%0d pad=%0b trunc=%0b want len=%0d pad=%0b trunc=%0b", tag, i,
                 obs_st[i].len, obs_st[i].padded, obs_st[i].trunc, exp_st[i].len, exp_st[i].padded, exp_st[i].trunc);
      end
    end
  endtask

  task automatic clear_q();
    obs_q.delete(); exp_q.delete(); obs_st.delete(); exp_st.delete();
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    length_min = LW'(v.mn);
    length_max = LW'(v.mx);
    clear_q();
    for (int k = 0; k < v.len; k++) begin
      fd[k] = 8'(v.base + v.step * k);
      fu[k] = 1'(k);
    end
    model(v.mn, v.mx, v.len);
    send_frame(v.len);
    s_if.tvalid = 1'b0;
    wait_done(exp_q.size(), 1);
    chk($sformatf("v%0d_out_len", i), obs_q.size(), v.exp_out);
    if (obs_st.size() > 0) begin
      chk($sformatf("v%0d_st_len", i), int'(obs_st[0].len), v.len);
      chk($sformatf("v%0d_padded", i), int'(obs_st[0].padded), int'(v.exp_pad));
      chk($sformatf("v%0d_trunc", i), int'(obs_st[0].trunc), int'(v.exp_trunc));
    end
    compare_all($sformatf("v%0d", i));
    $display("vec %0d min=%0d max=%0d len=%0d out_beats=%0d", i, v.mn, v.mx, v.len, obs_q.size());
  endtask

  initial begin
    vecs[0] = '{4, 0, 2, 8'hAA, 8'h11, 4, 1'b1, 1'b0};
    vecs[1] = '{0, 3, 5, 8'h01, 8'h01, 3, 1'b0, 1'b1};
    vecs[2] = '{0, 3, 3, 8'h21, 8'h01, 3, 1'b0, 1'b0};
    vecs[3] = '{0, 3, 4, 8'h31, 8'h01, 3, 1'b0, 1'b1};
    vecs[4] = '{6, 4, 2, 8'h41, 8'h01, 4, 1'b1, 1'b0};
    vecs[5] = '{1, 1, 1, 8'h5A, 8'h01, 1, 1'b0, 1'b0};
    vecs[6] = '{0, 0, 7, 8'h60, 8'h03, 7, 1'b0, 1'b0};
    vecs[7] = '{5, 5, 5, 8'h70, 8'h01, 5, 1'b0, 1'b0};
    vecs[8] = '{3, 0, 1, 8'h81, 8'h01, 3, 1'b1, 1'b0};

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    length_min = '0; length_max = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_if.tvalid, 0);
    chk("rst_st_valid", status_valid, 0);
    chk("rst_st_len", status_frame_len, 0);
    chk("rst_st_pad", status_padded, 0);
    chk("rst_st_trunc", status_truncated, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Random backpressure over back-to-back frames.
    rand_ready = 1'b1;
    length_min = 16'd8;
    length_max = 16'd16;
    clear_q();
    for (int f = 0; f < 100; f++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        fd[k] = 8'($urandom);
        fu[k] = 1'($urandom);
      end
      model(8, 16, len);
      send_frame(len);
      $display("rand frame %0d len=%0d", f, len);
    end
    s_if.tvalid = 1'b0;
    wait_done(exp_q.size(), 100);
    compare_all("rand");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset while padding: frame is abandoned, nothing else emerges.
    length_min = 16'd10;
    length_max = 16'd0;
    clear_q();
    send_beat(8'h55, 1'b0, 1'b0);
    send_beat(8'h66, 1'b1, 1'b1);
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("prst_m_valid", m_if.tvalid, 0);
    chk("prst_st_valid", status_valid, 0);
    chk("prst_st_len", status_frame_len, 0);
    chk("prst_st_pad", status_padded, 0);
    rst = 1'b1;
    obs_q.delete();
    obs_st.delete();
    repeat (15) @(posedge clk);
    #1;
    chk("prst_no_beats", obs_q.size(), 0);
    chk("prst_no_status", obs_st.size(), 0);
    $display("reset during pad done");
    run_vec(0);
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
